// File: rtl/parallel_io_port.sv
// rtl/parallel_io_port.sv - memory-mapped parallel I/O port: switches, LEDs, 7-seg HEX, edge IRQ
//
// Purpose: CPU IO-bus peripheral with debounced switch inputs, rising/falling
// edge capture with a maskable level interrupt, LED and HEX output registers,
// per-digit blanking and register readback.
//
// Ports:
//   Clock, Reset_L        system clock, asynchronous active-low reset
//   AS_L, WE_L, IO_Select bus strobe (low), write-not-read (0 = write), region select
//   Address, IO_data_in   byte address (bits [7:2] decoded), write data
//   IO_data_out           combinational read data, 0 when not reading
//   SW_input              asynchronous switch inputs
//   LEDR_output           LED register
//   HEX_output            active-low segments, digit i at [7i+6:7i]
//   IRQ                   registered level interrupt, |(EDGE & MASK)

module parallel_io_port #(
  parameter int NUM_SW          = 10,
  parameter int NUM_LED         = 9,
  parameter int NUM_HEX         = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic                 Clock,
  input  logic                 Reset_L,
  input  logic                 AS_L,
  input  logic                 WE_L,
  input  logic                 IO_Select,
  input  logic [31:0]          Address,
  input  logic [31:0]          IO_data_in,
  output logic [31:0]          IO_data_out,
  input  logic [NUM_SW-1:0]    SW_input,
  output logic [NUM_LED-1:0]   LEDR_output,
  output logic [7*NUM_HEX-1:0] HEX_output,
  output logic                 IRQ
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [5:0] REG_SW    = 6'h00;
  localparam logic [5:0] REG_LED   = 6'h01;
  localparam logic [5:0] REG_HEX   = 6'h02;
  localparam logic [5:0] REG_BLANK = 6'h03;
  localparam logic [5:0] REG_EDGE  = 6'h04;
  localparam logic [5:0] REG_MASK  = 6'h05;

  logic                 acc, wr_acc, rd_acc, wr_q, wr_commit;
  logic [5:0]           reg_sel;
  logic [NUM_LED-1:0]   led_q;
  logic [4*NUM_HEX-1:0] hex_q;
  logic [NUM_HEX-1:0]   blank_q;
  logic [NUM_SW-1:0]    sync1, sw_sync, sample, deb, dprev;
  logic [NUM_SW-1:0]    edge_q, mask_q, edge_set, edge_clr, rise, fall;
  logic [CNT_W-1:0]     cnt;
  logic                 tick, irq_q;
  logic [31:0]          rd_data;
  logic                 unused_bits;

  assign acc     = IO_Select & ~AS_L;
  assign wr_acc  = acc & ~WE_L;
  assign rd_acc  = acc & WE_L;
  assign reg_sel = Address[7:2];
  // Only the first clock of a held write strobe commits.
  assign wr_commit = wr_acc & ~wr_q;

  assign tick = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  assign rise = deb & ~dprev;
  assign fall = ~deb & dprev;

  always_comb begin
    edge_set = rise | fall;
    if (EDGE_MODE == 0) edge_set = rise;
    else if (EDGE_MODE == 1) edge_set = fall;
  end

  assign edge_clr = (wr_commit && reg_sel == REG_EDGE) ? IO_data_in[NUM_SW-1:0] : '0;

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      wr_q    <= 1'b0;
      led_q   <= '0;
      hex_q   <= '0;
      blank_q <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
      sync1   <= '0;
      sw_sync <= '0;
      sample  <= '0;
      deb     <= '0;
      dprev   <= '0;
      cnt     <= '0;
    end else begin
      wr_q    <= wr_acc;
      sync1   <= SW_input;
      sw_sync <= sync1;
      cnt     <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        sample <= sw_sync;
        // A bit only moves when two consecutive tick samples agree.
        deb    <= (deb & (sample ^ sw_sync)) | (sample & ~(sample ^ sw_sync));
      end
      dprev  <= deb;
      // Set has priority over a simultaneous write-one-to-clear.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      irq_q  <= |(edge_q & mask_q);
      if (wr_commit) begin
        case (reg_sel)
          REG_LED:   led_q   <= IO_data_in[NUM_LED-1:0];
          REG_HEX:   hex_q   <= IO_data_in[4*NUM_HEX-1:0];
          REG_BLANK: blank_q <= IO_data_in[NUM_HEX-1:0];
          REG_MASK:  mask_q  <= IO_data_in[NUM_SW-1:0];
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_acc) begin
      case (reg_sel)
        REG_SW:    rd_data[NUM_SW-1:0]    = deb;
        REG_LED:   rd_data[NUM_LED-1:0]   = led_q;
        REG_HEX:   rd_data[4*NUM_HEX-1:0] = hex_q;
        REG_BLANK: rd_data[NUM_HEX-1:0]   = blank_q;
        REG_EDGE:  rd_data[NUM_SW-1:0]    = edge_q;
        REG_MASK:  rd_data[NUM_SW-1:0]    = mask_q;
        default:   ;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_digit
    assign HEX_output[7*i +: 7] = blank_q[i] ? 7'h7F : seg7(hex_q[4*i +: 4]);
  end

  assign IO_data_out = rd_data;
  assign LEDR_output = led_q;
  assign IRQ         = irq_q;
  assign unused_bits = ^{Address[31:8], Address[1:0], IO_data_in};

endmodule
